program_out_serializer: RTL and testbench
=========================================

PROGRAM_OUT_SERIALIZER -- requirements
Module: program_out_serializer

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, number of 64-bit FIFO entries (power of two, 2..16).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 SHALL provide port program_out  input  64  result word driven by the multi-cycle computer.
REQ-005 SHALL provide port capt_valid  input  1  capture strobe; program_out is sampled when high.
REQ-006 SHALL provide port byte_data  output  8  serialized byte.
REQ-007 SHALL provide port byte_valid  output  1  byte_data holds a valid byte.
REQ-008 SHALL provide port byte_ready  input  1  downstream accepts the byte when high together with byte_valid.
REQ-009 SHALL provide port overflow  output  1  sticky flag: at least one capture was dropped.
REQ-010 SHALL provide port word_count  output  16  number of words fully transmitted.
REQ-011 SHALL provide port busy  output  1  high when the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-012 SHALL push program_out into the FIFO on a rising edge with capt_valid=1 and the FIFO not full.
REQ-013 SHALL, when the FIFO is full and no pop occurs that edge, drop the capture and set overflow to 1.
REQ-014 SHALL, when the FIFO is full and a pop occurs on the same edge, accept the push (count unchanged, overflow unchanged).
REQ-015 SHALL wrap the FIFO read/write pointers modulo DEPTH; FIFO order is first-in first-out.
REQ-016 SHALL implement FSM states IDLE and SEND only.
REQ-017 SHALL, in IDLE with the FIFO non-empty, pop the head word into a 64-bit shift register, clear the byte index to 0, and enter SEND.
REQ-018 SHALL, in SEND, drive byte_valid=1 and byte_data=shift register bits [7:0] (word transmitted LSB byte first).
REQ-019 SHALL hold byte_data and byte_valid stable while byte_valid=1 and byte_ready=0.
REQ-020 SHALL, on byte_valid and byte_ready both high, shift the register right by 8 and increment the byte index.
REQ-021 SHALL, on acceptance of byte index 7, increment word_count (wrapping 0xFFFF to 0x0000), then pop the next word and stay in SEND with index 0 if the FIFO is non-empty, else return to IDLE.
REQ-022 SHALL deliver latency: capture at edge k into an empty FIFO with the FSM in IDLE yields byte_valid=1 after edge k+1.
REQ-023 SHALL keep byte_valid=0 in IDLE.
REQ-024 SHALL clear overflow only by reset.

Reset
REQ-025 SHALL, on reset=0, immediately (asynchronously) clear the FIFO, enter IDLE, and drive byte_valid=0, byte_data=0x00, overflow=0, word_count=0, busy=0.
REQ-026 SHALL discard any partially transmitted word when reset is asserted mid-SEND, with no resumption after release.
REQ-027 SHALL ignore capt_valid while reset=0; the first capture is possible on the first rising edge after release.

Configuration
REQ-028 SHALL, when macro PROGRAM_OUT_DEDUP_EN is defined, drop any capture whose program_out equals the last accepted word (the register clears to 0 at reset, so a first capture of 0 is also dropped), without setting overflow.
REQ-029 SHALL, when PROGRAM_OUT_DEDUP_EN is not defined, push every capture that meets REQ-012 regardless of value.

Verification
REQ-030 SHALL cover: single capture 0x0807060504030201 with byte_ready=1 -> bytes 01,02,...,08 on consecutive cycles; word_count=1; busy=0 afterwards.
REQ-031 SHALL cover: byte_ready held 0 for 5 cycles mid-word -> byte_data constant, byte_valid=1 throughout, no byte lost.
REQ-032 SHALL cover: DEPTH=4, byte_ready=0, 6 consecutive captures -> one word in the shift register, 4 in the FIFO, 1 dropped, overflow=1; 40 bytes delivered after byte_ready is raised.
REQ-033 SHALL cover: reset pulsed low after 3 bytes of a word -> byte_valid=0 immediately, word_count=0, no further bytes without a new capture.
REQ-034 SHALL cover: with PROGRAM_OUT_DEDUP_EN defined, captures 0x5, 0x5, 0x6 -> 16 bytes sent, word_count=2, overflow=0; without the macro -> 24 bytes, word_count=3.

Source files
------------

// File: rtl/program_out_serializer.sv
// Captures 64-bit program results into a FIFO and streams them out LSB byte first.
// Optional build macro PROGRAM_OUT_DEDUP_EN drops captures equal to the last accepted word.
module program_out_serializer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] program_out,
  input  logic        capt_valid,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        overflow,
  output logic [15:0] word_count,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic IDLE = 1'b0;
  localparam logic SEND = 1'b1;

  logic          state_q, state_d;
  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   shift_q, shift_d;
  logic [2:0]    idx_q, idx_d;
  logic [15:0]   wc_q, wc_d;
  logic          ovf_q, ovf_d;

  logic          empty;
  logic          full;
  logic          accept;
  logic          last_byte;
  logic          pop;
  logic          dup;
  logic          push_req;
  logic          push;
  logic          drop;
  logic [63:0]   head;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(DEPTH));
  assign accept    = (state_q == SEND) && byte_ready;
  assign last_byte = accept && (idx_q == 3'd7);
  assign pop       = !empty && ((state_q == IDLE) || last_byte);
  assign head      = mem_q[rd_q];

`ifdef PROGRAM_OUT_DEDUP_EN
  logic [63:0] last_q, last_d;

  assign dup    = (program_out == last_q);
  assign last_d = push ? program_out : last_q;

  // Remember the most recently accepted word for duplicate filtering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= '0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // A full FIFO still takes a capture when the same edge frees a slot.
  assign push_req = capt_valid && !dup;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // FIFO pointer, occupancy and sticky overflow next-state.
  always_comb begin
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    rd_d  = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    ovf_d = ovf_q | drop;
  end

  // Serializer FSM: load a word, shift out 8 bytes, chain to the next word.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    wc_d    = wc_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = head;
          idx_d   = 3'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          shift_d = shift_q >> 8;
          idx_d   = idx_q + 3'd1;
          if (last_byte) begin
            wc_d = wc_q + 16'd1;
            if (pop) begin
              shift_d = head;
              idx_d   = 3'd0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= program_out;
    end
  end

  // Control and datapath state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      wc_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      wc_q    <= wc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign byte_valid = (state_q == SEND);
  assign byte_data  = byte_valid ? shift_q[7:0] : 8'h00;
  assign overflow   = ovf_q;
  assign word_count = wc_q;
  assign busy       = !empty || (state_q == SEND);

endmodule

// File: tb/tb_program_out_serializer.sv
// Directed bench for program_out_serializer.
// Byte stream is collected on falling edges and compared with hand-built words.
module tb_program_out_serializer;

  logic        clk;
  logic        reset;
  logic [63:0] program_out;
  logic        capt_valid;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        overflow;
  logic [15:0] word_count;
  logic        busy;

  int checks;
  int errors;
  logic [7:0] rx[$];
  logic [63:0] w[6];

  program_out_serializer #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .program_out(program_out),
    .capt_valid (capt_valid),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .overflow   (overflow),
    .word_count (word_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && byte_valid && byte_ready) rx.push_back(byte_data);
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rx_word(input int n);
    logic [63:0] v;
    v = '0;
    for (int b = 0; b < 8; b++) v[b*8 +: 8] = rx[n*8 + b];
    return v;
  endfunction

  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      if (!busy) break;
      tick();
    end
    check("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic capture(input logic [63:0] v);
    program_out = v;
    capt_valid  = 1'b1;
    tick();
    capt_valid  = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    rx.delete();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    program_out = '0;
    capt_valid  = 1'b0;
    byte_ready  = 1'b0;
    reset       = 1'b1;
    #1 reset    = 1'b0;
    #1;
    check("rst_valid", {63'd0, byte_valid}, 64'd0);
    check("rst_data",  {56'd0, byte_data},  64'd0);
    check("rst_ovf",   {63'd0, overflow},   64'd0);
    check("rst_wc",    {48'd0, word_count}, 64'd0);
    check("rst_busy",  {63'd0, busy},       64'd0);
    capt_valid = 1'b1;
    program_out = 64'hDEAD_BEEF_0000_0001;
    tick();
    tick();
    check("rst_ignore_capt", {63'd0, busy}, 64'd0);
    capt_valid = 1'b0;
    reset = 1'b1;
    rx.delete();

    // single word, consecutive bytes
    byte_ready = 1'b1;
    capture(64'h0807_0605_0403_0201);
    check("lat_pre_valid", {63'd0, byte_valid}, 64'd0);
    tick();
    check("lat_valid", {63'd0, byte_valid}, 64'd1);
    check("byte_0", {56'd0, byte_data}, 64'h01);
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("byte_%0d", i), {56'd0, byte_data}, 64'(i + 1));
    end
    tick();
    check("t1_valid_end", {63'd0, byte_valid}, 64'd0);
    check("t1_wc",        {48'd0, word_count}, 64'd1);
    check("t1_busy",      {63'd0, busy},       64'd0);
    check("t1_nbytes",    64'(rx.size()),      64'd8);

    // stall for 5 cycles mid-word
    rx.delete();
    capture(64'h1122_3344_5566_7788);
    tick();
    tick();
    tick();
    tick();
    byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_data",  {56'd0, byte_data},  64'h55);
      check("stall_valid", {63'd0, byte_valid}, 64'd1);
      tick();
    end
    byte_ready = 1'b1;
    wait_idle(40);
    check("t2_nbytes", 64'(rx.size()), 64'd8);
    check("t2_word",   rx_word(0),     64'h1122_3344_5566_7788);
    check("t2_wc",     {48'd0, word_count}, 64'd2);

    // six captures into a stalled DEPTH=4 pipe
    rx.delete();
    byte_ready = 1'b0;
    for (int i = 0; i < 6; i++) w[i] = 64'h1011_1213_1415_1617 + 64'(i) * 64'h0101_0101_0101_0101;
    for (int i = 0; i < 6; i++) capture(w[i]);
    check("ovf_set",   {63'd0, overflow},   64'd1);
    check("ovf_head",  {56'd0, byte_data},  {56'd0, w[0][7:0]});
    byte_ready = 1'b1;
    wait_idle(100);
    check("ovf_nbytes", 64'(rx.size()), 64'd40);
    for (int i = 0; i < 5; i++) check($sformatf("ovf_word%0d", i), rx_word(i), w[i]);
    check("ovf_wc",     {48'd0, word_count}, 64'd7);
    check("ovf_sticky", {63'd0, overflow},   64'd1);

    // reset after three bytes of a word
    rx.delete();
    capture(64'hCAFE_F00D_A5A5_5A5A);
    tick();
    tick();
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, byte_valid}, 64'd0);
    check("mid_rst_data",  {56'd0, byte_data},  64'd0);
    check("mid_rst_wc",    {48'd0, word_count}, 64'd0);
    check("mid_rst_ovf",   {63'd0, overflow},   64'd0);
    check("mid_rst_busy",  {63'd0, busy},       64'd0);
    check("mid_rst_got3",  64'(rx.size()),      64'd3);
    tick();
    reset = 1'b1;
    rx.delete();
    repeat (12) tick();
    check("post_rst_bytes", 64'(rx.size()),      64'd0);
    check("post_rst_valid", {63'd0, byte_valid}, 64'd0);

    // full FIFO accepts a push on the same edge as a pop
    byte_ready = 1'b0;
    for (int i = 0; i < 6; i++) w[i] = 64'hA0A1_A2A3_0000_0000 + 64'(i + 1);
    for (int i = 0; i < 5; i++) capture(w[i]);
    check("full_no_ovf", {63'd0, overflow}, 64'd0);
    byte_ready = 1'b1;
    repeat (7) tick();
    capture(w[5]);
    check("full_pop_ovf", {63'd0, overflow}, 64'd0);
    wait_idle(100);
    check("full_nbytes", 64'(rx.size()), 64'd48);
    for (int i = 0; i < 6; i++) check($sformatf("full_word%0d", i), rx_word(i), w[i]);
    check("full_wc", {48'd0, word_count}, 64'd6);

    // repeated value captures
    pulse_reset();
    capture(64'h5);
    capture(64'h5);
    capture(64'h6);
    wait_idle(100);
    check("dup_ovf", {63'd0, overflow}, 64'd0);
`ifdef PROGRAM_OUT_DEDUP_EN
    check("dup_nbytes", 64'(rx.size()), 64'd16);
    check("dup_wc",     {48'd0, word_count}, 64'd2);
    check("dup_word0",  rx_word(0), 64'h5);
    check("dup_word1",  rx_word(1), 64'h6);
`else
    check("dup_nbytes", 64'(rx.size()), 64'd24);
    check("dup_wc",     {48'd0, word_count}, 64'd3);
    check("dup_word0",  rx_word(0), 64'h5);
    check("dup_word1",  rx_word(1), 64'h5);
    check("dup_word2",  rx_word(2), 64'h6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
